// File: rtl/led_pkg.sv
// led_pkg: mode encodings and breathe ramp direction shared by the LED pattern generator
package led_pkg;

   typedef enum logic [1:0] {
      MODE_BLINK   = 2'b00,
      MODE_CHASE   = 2'b01,
      MODE_BREATHE = 2'b10,
      MODE_COUNT   = 2'b11
   } mode_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides the clock down to a one-cycle tick at TICK_HZ, frozen while enable is low
module tick_prescaler #(
   parameter int CLK_HZ  = 200_000_000,
   parameter int TICK_HZ = 1000
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   output logic tick
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int W   = $clog2(DIV);
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt;

   assign tick = enable && (cnt == LAST);

   // count 0..DIV-1 and wrap on the terminal count, holding while disabled
   always_ff @(posedge clock or posedge reset)
      if (reset)
         cnt <= '0;
      else if (enable)
         cnt <= tick ? '0 : cnt + W'(1);

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: Genesys II LED pattern generator (blink/chase/breathe/count); define SYNC_INPUTS_EN to synchronise mode/speed/pause
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int NUM_CH          = 8,
   parameter int CLK_HZ          = 200_000_000,
   parameter int TICK_HZ         = 1000,
   parameter int BASE_STEP_TICKS = 500,
   parameter int PWM_BITS        = 8
) (
   input  logic              sysclk_p,
   input  logic              sysclk_n,
   input  logic              reset,
   input  logic [1:0]        mode,
   input  logic [1:0]        speed,
   input  logic              pause,
   output logic [NUM_CH-1:0] led
);

   localparam int SW = $clog2(BASE_STEP_TICKS + 1);
   localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [SW-1:0]       STEP_BASE = SW'(BASE_STEP_TICKS);
   localparam logic [IW-1:0]       IDX_LAST  = IW'(NUM_CH - 1);
   localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
   localparam logic [NUM_CH-1:0]   LED_ONE   = {{(NUM_CH - 1){1'b0}}, 1'b1};

   logic                clk_200mhz;
   logic [1:0]          mode_s;
   logic [1:0]          speed_s;
   logic                pause_s;
   logic                tick;
   logic                step;
   logic                upd;
   logic                mode_chg;
   logic                pwm_on;
   mode_t               mode_q;
   dir_t                dir;
   dir_t                dir_nxt;
   logic [SW-1:0]       step_cnt;
   logic [SW-1:0]       step_len;
   logic [SW-1:0]       step_last;
   logic [2:0]          bdiv;
   logic [2:0]          bdiv_last;
   logic                blink;
   logic [IW-1:0]       idx;
   logic [NUM_CH-1:0]   cnt;
   logic [NUM_CH-1:0]   led_nxt;
   logic [PWM_BITS-1:0] duty;
   logic [PWM_BITS-1:0] duty_nxt;
   logic [PWM_BITS-1:0] pwm_cnt;

`ifdef SYNTHESIS
   IBUFGDS #(.IOSTANDARD("LVDS")) u_clk_buf (.I(sysclk_p), .IB(sysclk_n), .O(clk_200mhz));
`else
   assign clk_200mhz = sysclk_p & ~sysclk_n;
`endif

`ifdef SYNC_INPUTS_EN
   logic [4:0] sync_a;
   logic [4:0] sync_b;

   // two-flop synchroniser for the asynchronous switch inputs
   always_ff @(posedge clk_200mhz or posedge reset)
      if (reset) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= {mode, speed, pause};
         sync_b <= sync_a;
      end

   assign {mode_s, speed_s, pause_s} = sync_b;
`else
   assign {mode_s, speed_s, pause_s} = {mode, speed, pause};
`endif

   tick_prescaler #(
      .CLK_HZ  (CLK_HZ),
      .TICK_HZ (TICK_HZ)
   ) u_prescaler (
      .clock  (clk_200mhz),
      .reset  (reset),
      .enable (!pause_s),
      .tick   (tick)
   );

   // step and breathe-update strobes; a zero step length behaves as one tick per step
   always_comb begin
      step_len  = STEP_BASE >> speed_s;
      step_last = (step_len == '0) ? '0 : step_len - SW'(1);
      bdiv_last = 3'd7 >> speed_s;
      step      = tick && (step_cnt >= step_last);
      upd       = tick && (bdiv >= bdiv_last);
      mode_chg  = mode_s != mode_q;
   end

   // triangular breathe ramp, turning around after one update at each endpoint
   always_comb begin
      dir_nxt  = (dir == DIR_UP && duty == DUTY_MAX) ? DIR_DOWN :
                 (dir == DIR_DOWN && duty == '0) ? DIR_UP : dir;
      duty_nxt = (dir_nxt == DIR_UP) ? duty + PWM_BITS'(1) : duty - PWM_BITS'(1);
   end

   // pattern state; a mode change clears everything but the prescaler and beats a coincident step
   always_ff @(posedge clk_200mhz or posedge reset)
      if (reset) begin
         mode_q   <= MODE_BLINK;
         step_cnt <= '0;
         bdiv     <= '0;
         blink    <= 1'b0;
         idx      <= '0;
         cnt      <= '0;
         duty     <= '0;
         dir      <= DIR_UP;
      end else begin
         mode_q <= mode_t'(mode_s);
         if (mode_chg) begin
            step_cnt <= '0;
            bdiv     <= '0;
            blink    <= 1'b0;
            idx      <= '0;
            cnt      <= '0;
            duty     <= '0;
            dir      <= DIR_UP;
         end else begin
            if (tick) step_cnt <= step ? '0 : step_cnt + SW'(1);
            if (tick) bdiv <= upd ? '0 : bdiv + 3'd1;
            if (step) begin
               blink <= ~blink;
               idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
               cnt   <= cnt + NUM_CH'(1);
            end
            if (upd) begin
               duty <= duty_nxt;
               dir  <= dir_nxt;
            end
         end
      end

   // LED image for the active mode
   always_comb begin
      pwm_on  = pwm_cnt < duty;
      led_nxt = (mode_q == MODE_BLINK) ? {NUM_CH{blink}} :
                (mode_q == MODE_CHASE) ? LED_ONE << idx :
                (mode_q == MODE_COUNT) ? cnt : {NUM_CH{pwm_on}};
   end

   // free-running PWM counter and registered LED drive
   always_ff @(posedge clk_200mhz or posedge reset)
      if (reset) begin
         pwm_cnt <= '0;
         led     <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
         led     <= led_nxt;
      end

endmodule
